// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver, 8N1, LSB first.
// rx is double-flopped, then sampled three times around mid-bit with a 2-of-3
// majority vote. Bit timing is phase-locked to the start edge by restarting the
// tick divider when a frame begins. Received bytes are presented on dout with a
// rdy handshake; frame_err and overrun are sticky until err_clr.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle; waits for a low after having seen the line high
// S_START | validating the start bit; a high majority is a false start
// S_DATA  | shifting in 8 data bits, LSB first
// S_STOP  | stop bit decided mid-bit, then straight back to idle
module uart_rx_oversampled #(
    parameter int CLK_HZ     = 64000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rdy_clr,
    input  logic       err_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] T_PRE    = CW'(M - 1);
    localparam logic [CW-1:0] T_MID    = CW'(M);
    localparam logic [CW-1:0] T_DEC    = CW'(M + 1);
    localparam logic [CW-1:0] T_LAST   = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    samp_q, samp_d;
    logic          rx_meta_q, rx_sync_q;
    logic          armed_q, armed_d;
    logic [7:0]    dout_q, dout_d;
    logic          rdy_q, rdy_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic tick;
    logic maj;
    logic decide;

    // Two-flop synchronizer; both stages read as idle-high in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State register for the FSM, timing counters and output flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            samp_q      <= '0;
            armed_q     <= 1'b0;
            dout_q      <= 8'h00;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            armed_q     <= armed_d;
            dout_q      <= dout_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: tick generation, bit sampling, and byte hand-off.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        armed_d     = armed_q;
        dout_d      = dout_q;
        rdy_d       = rdy_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        decide      = 1'b0;

        tick = (div_q == DIV_LAST);
        maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

        if (state_q == S_IDLE) begin
            div_d      = '0;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
                tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + CW'(1);
                if (tick_cnt_q == T_PRE) samp_d[0] = rx_sync_q;
                if (tick_cnt_q == T_MID) samp_d[1] = rx_sync_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                // A held-low line (break) must go high before another start is accepted.
                if (rx_sync_q) armed_d = 1'b1;
                if (armed_q && !rx_sync_q) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                if (tick && tick_cnt_q == T_DEC && maj) begin
                    state_d = S_IDLE;
                end else if (tick && tick_cnt_q == T_LAST) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick && tick_cnt_q == T_DEC) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (tick && tick_cnt_q == T_LAST) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick && tick_cnt_q == T_DEC) begin
                    decide  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_clr) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (rdy_clr) rdy_d = 1'b0;

        // A set on the decision cycle overrides any clear in the same cycle.
        if (decide) begin
            if (maj) begin
                if (!rdy_q || rdy_clr) begin
                    dout_d = shift_q;
                    rdy_d  = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign dout      = dout_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled at 16 clocks per bit (DIV = 1).
// Stimulus pushes each expected byte load, with the clock count at which it must
// appear, into a queue; a negedge monitor pops and compares on every visible load.
// Load latency: rx falls just after edge k; 2 synchronizer edges, 1 idle-detect
// edge, 16 start + 128 data clocks, then the stop decision at tick 9 of the stop
// bit, plus one edge for the output register -> visible after edge k+157.
module tb_uart_rx_oversampled;

    localparam int LAT = 157;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rdy_clr = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_oversampled #(
        .CLK_HZ(1600000),
        .BAUD(100000),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .rdy_clr(rdy_clr),
        .err_clr(err_clr),
        .dout(dout),
        .rdy(rdy),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         at;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   k;

    logic [7:0] dout_prev = 8'h00;
    logic       rdy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: any rdy rise or dout change outside reset is a byte load.
    always @(negedge clk) begin
        if (rst_n && ((rdy && !rdy_prev) || (dout !== dout_prev))) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL load: unexpected load dout=%0h at cycle %0d", dout, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (dout !== mon_e.data || cyc != mon_e.at) begin
                    bad++;
                    $display("FAIL load: got dout=%0h at cycle %0d want %0h at cycle %0d",
                             dout, cyc, mon_e.data, mon_e.at);
                end
            end
        end
        dout_prev = dout;
        rdy_prev  = rdy;
    end

    task automatic tick_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_v, input logic expect_load,
                        input logic clr_at_dec);
        logic [9:0] fr;
        exp_t       e;
        fr = {stop_v, d, 1'b0};
        @(posedge clk);
        #1;
        if (expect_load) begin
            e.at   = cyc + LAT;
            e.data = d;
            sb.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            if (i == 9 && clr_at_dec) begin
                tick_edges(12);
                rdy_clr = 1'b1;
                tick_edges(1);
                rdy_clr = 1'b0;
                tick_edges(3);
            end else begin
                tick_edges(16);
            end
        end
        rx = 1'b1;
        tick_edges(4);
    endtask

    task automatic ack();
        rdy_clr = 1'b1;
        tick_edges(1);
        rdy_clr = 1'b0;
        tick_edges(1);
    endtask

    task automatic eclr();
        err_clr = 1'b1;
        tick_edges(1);
        err_clr = 1'b0;
        tick_edges(1);
    endtask

    initial begin
        rst_n = 1'b0;
        tick_edges(3);
        chk("rst_dout", dout, 8'h00);
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick_edges(4);

        // Stop bit low: frame error, byte discarded.
        send(8'h55, 1'b0, 1'b0, 1'b0);
        chk("ferr_set", frame_err, 1'b1);
        chk("ferr_rdy", rdy, 1'b0);
        chk("ferr_dout", dout, 8'h00);
        chk("ferr_overrun", overrun, 1'b0);
        eclr();
        chk("ferr_clr", frame_err, 1'b0);

        // Clean frame.
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("a5_dout", dout, 8'hA5);
        chk("a5_rdy", rdy, 1'b1);
        chk("a5_ferr", frame_err, 1'b0);
        ack();
        chk("a5_ack", rdy, 1'b0);

        // Overrun: second byte dropped while first unacknowledged.
        send(8'h3C, 1'b1, 1'b1, 1'b0);
        send(8'hC3, 1'b1, 1'b0, 1'b0);
        chk("ovr_dout", dout, 8'h3C);
        chk("ovr_rdy", rdy, 1'b1);
        chk("ovr_set", overrun, 1'b1);
        eclr();
        chk("ovr_clr", overrun, 1'b0);
        ack();

        // False start: 4-clock glitch.
        @(posedge clk);
        #1;
        k = cyc;
        rx = 1'b0;
        tick_edges(4);
        rx = 1'b1;
        chk("glitch_busy_hi", busy, 1'b1);
        tick_edges(16);
        chk("glitch_busy_lo", busy, 1'b0);
        chk("glitch_rdy", rdy, 1'b0);
        chk("glitch_dout", dout, 8'h3C);
        chk("glitch_ferr", frame_err, 1'b0);
        chk("glitch_ovr", overrun, 1'b0);

        // Ack in the decision cycle lets the new byte replace the old one.
        send(8'h12, 1'b1, 1'b1, 1'b0);
        chk("hold12_dout", dout, 8'h12);
        send(8'h34, 1'b1, 1'b1, 1'b1);
        chk("swap_dout", dout, 8'h34);
        chk("swap_rdy", rdy, 1'b1);
        chk("swap_ovr", overrun, 1'b0);
        ack();

        // Reset during bit 4 of 0xFF, then a clean frame.
        @(posedge clk);
        #1;
        rx = 1'b0;
        tick_edges(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick_edges(16);
        end
        tick_edges(8);
        chk("midrst_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        tick_edges(3);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_rdy", rdy, 1'b0);
        rst_n = 1'b1;
        tick_edges(8);
        chk("midrst_idle", busy, 1'b0);
        send(8'h81, 1'b1, 1'b1, 1'b0);
        chk("x81_dout", dout, 8'h81);
        chk("x81_rdy", rdy, 1'b1);
        chk("x81_ferr", frame_err, 1'b0);
        chk("x81_ovr", overrun, 1'b0);
        ack();

        // Break: one frame error, no restart until the line goes high.
        @(posedge clk);
        #1;
        rx = 1'b0;
        tick_edges(190);
        chk("brk_ferr", frame_err, 1'b1);
        chk("brk_busy", busy, 1'b0);
        chk("brk_rdy", rdy, 1'b0);
        chk("brk_dout", dout, 8'h81);
        tick_edges(10);
        rx = 1'b1;
        tick_edges(4);
        eclr();
        chk("brk_ferr_clr", frame_err, 1'b0);
        send(8'h7E, 1'b1, 1'b1, 1'b0);
        chk("x7e_dout", dout, 8'h7E);
        chk("x7e_rdy", rdy, 1'b1);

        tick_edges(5);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
